// File: rtl/keypad_if.sv
// Keypad scanner board-side and key-event signals.
// slave is the scanner; master is the board/consumer side.
interface keypad_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    output col_n,
    input  row_n,
    input  key_code,
    input  key_valid,
    input  key_down
  );

  modport slave (
    input  col_n,
    output row_n,
    output key_code,
    output key_valid,
    output key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Reports one hex code per press, with 2-key lockout.
module keypad_scan #(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] AGREE_MAX = AW'(DEBOUNCE_SCANS);

  typedef enum logic {
    IDLE,
    PRESSED
  } state_t;

  logic [3:0]    col_m;
  logic [3:0]    col_q;
  logic [3:0]    col_s;
  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [3:0]    row_n_q;
  logic [15:0]   snap;
  logic [15:0]   prev;
  logic [15:0]   deb;
  logic [15:0]   s_full;
  logic [AW-1:0] agree;
  logic [AW-1:0] agree_nxt;
  logic          sample;
  logic          scan_end;
  state_t        state;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          down_q;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    lowest = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) lowest = 4'(i);
    end
  endfunction

  assign col_s    = ~col_q;
  assign sample   = (div == DIV_LAST);
  assign scan_end = sample && (row == 2'd3);
  assign s_full   = {col_s, snap[11:0]};

  always_comb begin
    agree_nxt = agree;
    if (s_full != prev) begin
      agree_nxt = AW'(1);
    end else if (agree != AGREE_MAX) begin
      agree_nxt = agree + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= 4'hF;
      col_q <= 4'hF;
    end else begin
      col_m <= kp.col_n;
      col_q <= col_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      row     <= '0;
      row_n_q <= 4'b1110;
      snap    <= '0;
      prev    <= '0;
      agree   <= AGREE_MAX;
      deb     <= '0;
    end else if (sample) begin
      div     <= '0;
      row     <= row + 2'd1;
      row_n_q <= ~(4'b0001 << (row + 2'd1));
      snap[{row, 2'b00} +: 4] <= col_s;
      if (scan_end) begin
        prev  <= s_full;
        agree <= agree_nxt;
        if (agree_nxt == AGREE_MAX) deb <= s_full;
      end
    end else begin
      div <= div + DW'(1);
    end
  end

  // Lockout: while PRESSED, only a full release returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (deb != '0) begin
            state   <= PRESSED;
            code_q  <= lowest(deb);
            valid_q <= 1'b1;
            down_q  <= 1'b1;
          end
        end
        PRESSED: begin
          if (deb == '0) begin
            state  <= IDLE;
            down_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          down_q <= 1'b0;
        end
      endcase
    end
  end

  assign kp.row_n     = row_n_q;
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural key matrix.
// SCAN_DIV=4, DEBOUNCE_SCANS=3: 16-cycle scans.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          base;

  keypad_if kp();

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Matrix: a held key pulls its column low while its row is driven
  always_comb begin
    kp.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.row_n[r]) kp.col_n[c] = 1'b0;
  end

  always @(negedge clk) if (kp.key_valid) pulses++;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycles(2);
    checks++;
    if (kp.row_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_row_n: got %b want 1110", kp.row_n);
    end
    checks++;
    if ({kp.key_valid, kp.key_down, kp.key_code} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs: got v=%b d=%b c=%h want 0 0 0",
               kp.key_valid, kp.key_down, kp.key_code);
    end
  endtask

  task automatic test_idle_scan;
    logic [3:0] exp;
    base = pulses;
    rst  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (kp.row_n !== exp) begin
        errors++;
        $display("FAIL idle_row_n[%0d]: got %b want %b", i, kp.row_n, exp);
      end
      cycles(1);
    end
    cycles(48);
    checks++;
    if (pulses - base !== 0 || kp.key_down !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: got pulses=%0d down=%b want 0 0",
               pulses - base, kp.key_down);
    end
  endtask

  task automatic test_press_release;
    base = pulses;
    keys[9] = 1'b1;
    cycles(70);
    checks++;
    if (pulses - base !== 1) begin
      errors++;
      $display("FAIL press9_pulses: got %0d want 1", pulses - base);
    end
    checks++;
    if (kp.key_code !== 4'd9 || kp.key_down !== 1'b1) begin
      errors++;
      $display("FAIL press9_state: got code=%h down=%b want 9 1",
               kp.key_code, kp.key_down);
    end
    keys[9] = 1'b0;
    cycles(80);
    checks++;
    if (kp.key_down !== 1'b0 || kp.key_code !== 4'd9 || pulses - base !== 1) begin
      errors++;
      $display("FAIL release9: got down=%b code=%h pulses=%0d want 0 9 1",
               kp.key_down, kp.key_code, pulses - base);
    end
  endtask

  task automatic test_bounce;
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      keys[9] = ~keys[9];
      cycles(20);
    end
    checks++;
    if (pulses - base !== 0) begin
      errors++;
      $display("FAIL bounce_quiet: got pulses=%0d want 0", pulses - base);
    end
    keys[9] = 1'b1;
    cycles(80);
    checks++;
    if (pulses - base !== 1 || kp.key_code !== 4'd9) begin
      errors++;
      $display("FAIL bounce_hold: got pulses=%0d code=%h want 1 9",
               pulses - base, kp.key_code);
    end
    keys[9] = 1'b0;
    cycles(80);
  endtask

  task automatic test_multi_key;
    base = pulses;
    keys[3] = 1'b1;
    keys[4] = 1'b1;
    cycles(80);
    checks++;
    if (pulses - base !== 1 || kp.key_code !== 4'd3) begin
      errors++;
      $display("FAIL multi_press: got pulses=%0d code=%h want 1 3",
               pulses - base, kp.key_code);
    end
    keys[3] = 1'b0;
    cycles(100);
    checks++;
    if (pulses - base !== 1 || kp.key_code !== 4'd3 || kp.key_down !== 1'b1) begin
      errors++;
      $display("FAIL lockout: got pulses=%0d code=%h down=%b want 1 3 1",
               pulses - base, kp.key_code, kp.key_down);
    end
    keys[4] = 1'b0;
    cycles(80);
    checks++;
    if (kp.key_down !== 1'b0) begin
      errors++;
      $display("FAIL multi_release: got down=%b want 0", kp.key_down);
    end
    keys[15] = 1'b1;
    cycles(80);
    checks++;
    if (pulses - base !== 2 || kp.key_code !== 4'hF) begin
      errors++;
      $display("FAIL press15: got pulses=%0d code=%h want 2 f",
               pulses - base, kp.key_code);
    end
    keys[15] = 1'b0;
    cycles(80);
  endtask

  task automatic test_reset_mid_press;
    base = pulses;
    keys[9] = 1'b1;
    cycles(80);
    checks++;
    if (kp.key_down !== 1'b1 || kp.key_code !== 4'd9) begin
      errors++;
      $display("FAIL pre_rst_press: got down=%b code=%h want 1 9",
               kp.key_down, kp.key_code);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (kp.row_n !== 4'b1110 || {kp.key_valid, kp.key_down, kp.key_code} !== 6'b0) begin
      errors++;
      $display("FAIL async_rst: got row_n=%b v=%b d=%b c=%h want 1110 0 0 0",
               kp.row_n, kp.key_valid, kp.key_down, kp.key_code);
    end
    cycles(2);
    base = pulses;
    rst = 1'b0;
    cycles(80);
    checks++;
    if (pulses - base !== 1 || kp.key_code !== 4'd9 || kp.key_down !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_press: got pulses=%0d code=%h down=%b want 1 9 1",
               pulses - base, kp.key_code, kp.key_down);
    end
    keys[9] = 1'b0;
    cycles(80);
  endtask

  task automatic test_back_to_back;
    base = pulses;
    keys[0] = 1'b1;
    cycles(80);
    keys[0] = 1'b0;
    cycles(80);
    checks++;
    if (kp.key_down !== 1'b0 || kp.key_code !== 4'd0) begin
      errors++;
      $display("FAIL b2b_release: got down=%b code=%h want 0 0",
               kp.key_down, kp.key_code);
    end
    keys[0] = 1'b1;
    cycles(80);
    checks++;
    if (pulses - base !== 2 || kp.key_code !== 4'd0) begin
      errors++;
      $display("FAIL b2b_press: got pulses=%0d code=%h want 2 0",
               pulses - base, kp.key_code);
    end
    keys[0] = 1'b0;
  endtask

  initial begin
    test_reset;
    test_idle_scan;
    test_press_release;
    test_bounce;
    test_multi_key;
    test_reset_mid_press;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
